// File: rtl/apuf_challenge_sequencer_pkg.sv
// Shared types and constants for the arbiter-PUF challenge sequencer.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package apuf_challenge_sequencer_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_LOAD,
        ST_FIRE,
        ST_WAIT,
        ST_RELAX,
        ST_VOTE,
        ST_OUT,
        ST_DONE
    } state_t;

    // Right-shifting Galois form of x^64+x^63+x^61+x^60+1:
    // exponents 64,63,61,60 map to mask bits 63,62,60,59.
    localparam logic [63:0] LFSR_TAPS    = 64'hD800_0000_0000_0000;
    localparam logic [63:0] DEFAULT_SEED = 64'hACE1_0000_0000_0001;

    function automatic logic [63:0] lfsr_next(input logic [63:0] v);
        return v[0] ? ((v >> 1) ^ LFSR_TAPS) : (v >> 1);
    endfunction

endpackage

// File: rtl/apuf_lfsr64.sv
// 64-bit Galois LFSR challenge source with synchronous load and step.
// Latency: load/step take effect on the next clk edge.
// Backpressure: none; holds its value whenever neither load nor step is set.
// Ports: clk, rst_n (async low), load/load_val (zero maps to SEED), step, q.
module apuf_lfsr64
    import apuf_challenge_sequencer_pkg::*;
#(
    parameter logic [63:0] SEED = DEFAULT_SEED
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        load,
    input  logic [63:0] load_val,
    input  logic        step,
    output logic [63:0] q
);

    logic [63:0] q_q;
    logic [63:0] q_d;

    // An all-zero state would lock the register, so a zero load falls back to SEED.
    always_comb begin
        q_d = q_q;
        if (load) begin
            q_d = (load_val == 64'd0) ? SEED : load_val;
        end else if (step) begin
            q_d = lfsr_next(q_q);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            q_q <= SEED;
        end else begin
            q_q <= q_d;
        end
    end

    assign q = q_q;

endmodule

// File: rtl/apuf_challenge_sequencer.sv
// Drives arbiter-PUF challenges/triggers, majority-votes NREP responses, packs words.
// Latency: ~ SETTLE + NREP*(TRIG_W + response + RELAX) cycles per voted bit.
// Backpressure: holds word_valid/word_data in OUT until word_ready; no PUF activity meanwhile.
// Ports: start/num_words/seed_load/seed control; cT/cB/tigSignal <-> respReady/respBit to PUF;
//        word_valid/word_ready/word_data stream; busy, done pulse, sticky timeout_err.
module apuf_challenge_sequencer
    import apuf_challenge_sequencer_pkg::*;
#(
    parameter int          NSTAGE  = 64,
    parameter int          NREP    = 7,
    parameter int          RESP_W  = 32,
    parameter int          SETTLE  = 8,
    parameter int          TRIG_W  = 4,
    parameter int          RELAX   = 16,
    parameter int          TIMEOUT = 255,
    parameter logic [63:0] SEED    = DEFAULT_SEED
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic [15:0]       num_words,
    input  logic              seed_load,
    input  logic [NSTAGE-1:0] seed,
    output logic [NSTAGE-1:0] cT,
    output logic [NSTAGE-1:0] cB,
    output logic              tigSignal,
    input  logic              respReady,
    input  logic              respBit,
    output logic              word_valid,
    input  logic              word_ready,
    output logic [RESP_W-1:0] word_data,
    output logic              busy,
    output logic              done,
    output logic              timeout_err
);

    localparam int              BW        = (RESP_W > 1) ? $clog2(RESP_W) : 1;
    localparam logic [15:0]     SETTLE_M1 = 16'(SETTLE - 1);
    localparam logic [15:0]     TRIG_M1   = 16'(TRIG_W - 1);
    localparam logic [15:0]     RELAX_M1  = 16'(RELAX - 1);
    localparam logic [15:0]     TO_M1     = 16'(TIMEOUT - 1);
    localparam logic [7:0]      NREP_M1   = 8'(NREP - 1);
    localparam logic [7:0]      MAJ       = 8'(NREP / 2);
    localparam logic [BW-1:0]   LAST_BIT  = BW'(RESP_W - 1);

    state_t            state_q, state_d;
    logic [15:0]       cnt_q, cnt_d;
    logic [7:0]        ones_q, ones_d;
    logic [7:0]        rep_q, rep_d;
    logic [BW-1:0]     bitcnt_q, bitcnt_d;
    logic [15:0]       wcnt_q, wcnt_d;
    logic [15:0]       nwords_q, nwords_d;
    logic [RESP_W-1:0] word_q, word_d;
    logic              terr_q, terr_d;
    logic              zdone_q, zdone_d;
    logic [2:0]        rr_q, rr_d;

    logic              rr_rise;
    logic              lfsr_load;
    logic              lfsr_step;
    logic [63:0]       lfsr_q;

    // rr_q[1:0] is the two-flop synchroniser; rr_q[2] is the edge-detect history.
    assign rr_rise = rr_q[1] & ~rr_q[2];

    apuf_lfsr64 #(.SEED(SEED)) u_lfsr (
        .clk      (clk),
        .rst_n    (rst_n),
        .load     (lfsr_load),
        .load_val (64'(seed)),
        .step     (lfsr_step),
        .q        (lfsr_q)
    );

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:  if (start && num_words != 16'd0) state_d = ST_LOAD;
            ST_LOAD:  if (cnt_q == SETTLE_M1) state_d = ST_FIRE;
            ST_FIRE:  if (cnt_q == TRIG_M1) state_d = ST_WAIT;
            ST_WAIT:  if (rr_rise || cnt_q == TO_M1) state_d = ST_RELAX;
            // Never re-trigger while the previous response is still asserted.
            ST_RELAX: if (cnt_q >= RELAX_M1 && !rr_q[1])
                          state_d = (rep_q < NREP_M1) ? ST_FIRE : ST_VOTE;
            ST_VOTE:  state_d = (bitcnt_q == LAST_BIT) ? ST_OUT : ST_LOAD;
            ST_OUT:   if (word_ready)
                          state_d = (wcnt_q + 16'd1 == nwords_q) ? ST_DONE : ST_LOAD;
            ST_DONE:  state_d = ST_IDLE;
            default:  state_d = ST_IDLE;
        endcase
    end

    // Outputs; the challenge is the LFSR itself, which only moves in IDLE and VOTE.
    always_comb begin
        tigSignal   = (state_q == ST_FIRE) || (state_q == ST_WAIT);
        word_valid  = (state_q == ST_OUT);
        busy        = (state_q != ST_IDLE);
        done        = (state_q == ST_DONE) || zdone_q;
        lfsr_load   = (state_q == ST_IDLE) && seed_load;
        lfsr_step   = (state_q == ST_VOTE);
        cT          = NSTAGE'(lfsr_q);
        cB          = NSTAGE'(lfsr_q);
        word_data   = word_q;
        timeout_err = terr_q;
    end

    // Datapath: phase timer, vote counter, packer, word counter.
    always_comb begin
        rr_d     = {rr_q[1:0], respReady};
        cnt_d    = (state_d != state_q) ? 16'd0 :
                   (cnt_q == 16'hFFFF) ? cnt_q : cnt_q + 16'd1;
        ones_d   = ones_q;
        rep_d    = rep_q;
        bitcnt_d = bitcnt_q;
        wcnt_d   = wcnt_q;
        nwords_d = nwords_q;
        word_d   = word_q;
        terr_d   = terr_q;
        zdone_d  = 1'b0;
        case (state_q)
            ST_IDLE: if (start) begin
                ones_d   = 8'd0;
                rep_d    = 8'd0;
                bitcnt_d = '0;
                wcnt_d   = 16'd0;
                terr_d   = 1'b0;
                nwords_d = num_words;
                zdone_d  = (num_words == 16'd0);
            end
            ST_WAIT: begin
                if (rr_rise) begin
                    ones_d = ones_q + 8'(respBit);
                end else if (cnt_q == TO_M1) begin
                    terr_d = 1'b1;
                end
            end
            ST_RELAX: if (state_d == ST_FIRE) rep_d = rep_q + 8'd1;
            ST_VOTE: begin
                word_d[bitcnt_q] = (ones_q > MAJ);
                ones_d   = 8'd0;
                rep_d    = 8'd0;
                bitcnt_d = (bitcnt_q == LAST_BIT) ? '0 : bitcnt_q + 1'b1;
            end
            ST_OUT: if (word_ready) wcnt_d = wcnt_q + 16'd1;
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q    <= 16'd0;
            ones_q   <= 8'd0;
            rep_q    <= 8'd0;
            bitcnt_q <= '0;
            wcnt_q   <= 16'd0;
            nwords_q <= 16'd0;
            word_q   <= '0;
            terr_q   <= 1'b0;
            zdone_q  <= 1'b0;
            rr_q     <= 3'd0;
        end else begin
            cnt_q    <= cnt_d;
            ones_q   <= ones_d;
            rep_q    <= rep_d;
            bitcnt_q <= bitcnt_d;
            wcnt_q   <= wcnt_d;
            nwords_q <= nwords_d;
            word_q   <= word_d;
            terr_q   <= terr_d;
            zdone_q  <= zdone_d;
            rr_q     <= rr_d;
        end
    end

endmodule

// File: tb/tb_apuf_challenge_sequencer.sv
module tb_apuf_challenge_sequencer;

    localparam int          NREP   = 7;
    localparam int          RESP_W = 32;
    localparam int          TRIG_W = 4;
    localparam int          TO     = 40;
    localparam logic [63:0] SEED   = 64'hACE1_0000_0000_0001;
    localparam logic [63:0] KEY    = 64'h9E37_79B9_7F4A_7C15;
    // Taps for x^64+x^63+x^61+x^60+1 in right-shift Galois form.
    localparam logic [63:0] TAPS   = (64'd1 << 63) | (64'd1 << 62) | (64'd1 << 60) | (64'd1 << 59);

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic              start = 1'b0;
    logic [15:0]       num_words = 16'd0;
    logic              seed_load = 1'b0;
    logic [63:0]       seed = 64'd0;
    logic [63:0]       cT, cB;
    logic              tigSignal;
    logic              respReady = 1'b0;
    logic              respBit = 1'b0;
    logic              word_valid;
    logic              word_ready = 1'b1;
    logic [RESP_W-1:0] word_data;
    logic              busy, done, timeout_err;

    int          n_checks = 0;
    int          n_fail = 0;
    int          hs_count = 0;
    logic [31:0] sb[$];
    logic [63:0] ref_lfsr = SEED;
    bit          model_en = 1'b1;
    int          flip_reps = 0;

    always #5 clk = ~clk;

    apuf_challenge_sequencer #(
        .NSTAGE(64), .NREP(NREP), .RESP_W(RESP_W), .SETTLE(8), .TRIG_W(TRIG_W),
        .RELAX(16), .TIMEOUT(TO), .SEED(SEED)
    ) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .num_words(num_words),
        .seed_load(seed_load), .seed(seed), .cT(cT), .cB(cB), .tigSignal(tigSignal),
        .respReady(respReady), .respBit(respBit), .word_valid(word_valid),
        .word_ready(word_ready), .word_data(word_data), .busy(busy), .done(done),
        .timeout_err(timeout_err)
    );

    // Behavioural arbiter PUF: responds 5 clk after trigger rise, drops when trigger falls.
    logic        tig_prev = 1'b0;
    logic        pend_bit = 1'b0;
    int          timer = 0;
    int          rep_idx = 0;
    logic [63:0] last_chal = 64'd0;
    always begin
        @(posedge clk);
        #1;
        if (tigSignal && !tig_prev) begin
            if (cT !== last_chal) begin
                rep_idx = 0;
                last_chal = cT;
            end else begin
                rep_idx++;
            end
            pend_bit = (^(cT & KEY)) ^ (rep_idx < flip_reps);
            timer = 5;
        end else if (!tigSignal) begin
            respReady = 1'b0;
            timer = 0;
        end else if (timer > 0) begin
            timer--;
            if (timer == 0 && model_en) begin
                respReady = 1'b1;
                respBit = pend_bit;
            end
        end
        tig_prev = tigSignal;
    end

    // Scoreboard: compare each handshaked word with the oldest expected word.
    logic [31:0] exp_w;
    always @(negedge clk) begin
        if (rst_n && word_valid && word_ready) begin
            hs_count++;
            n_checks++;
            if (sb.size() == 0) begin
                n_fail++;
                $display("FAIL word_unexpected: got %h, required no word", word_data);
            end else begin
                exp_w = sb.pop_front();
                if (word_data !== exp_w) begin
                    n_fail++;
                    $display("FAIL word_data: got %h, required %h", word_data, exp_w);
                end
            end
        end
    end

    function automatic logic [63:0] ref_step(input logic [63:0] v);
        return v[0] ? ((v >> 1) ^ TAPS) : (v >> 1);
    endfunction

    task automatic push_run(input int n, input int flips, input bit to_mode);
        logic [31:0] w;
        for (int i = 0; i < n; i++) begin
            w = '0;
            for (int b = 0; b < RESP_W; b++) begin
                w[b] = to_mode ? 1'b0 : ((^(ref_lfsr & KEY)) ^ (flips > NREP / 2));
                ref_lfsr = ref_step(ref_lfsr);
            end
            sb.push_back(w);
        end
    endtask

    task automatic start_run(input int n);
        @(posedge clk); #1;
        num_words = 16'(n);
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
    endtask

    task automatic wait_done(input int budget, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < budget; i++) begin
            @(negedge clk);
            if (done) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    task automatic test_reset;
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        n_checks++;
        if ({tigSignal, word_valid, busy, done, timeout_err} !== 5'b0) begin
            n_fail++;
            $display("FAIL reset_ctrl: got %b, required 00000",
                     {tigSignal, word_valid, busy, done, timeout_err});
        end
        n_checks++;
        if (cT !== SEED || cB !== SEED || word_data !== '0) begin
            n_fail++;
            $display("FAIL reset_data: got cT=%h cB=%h wd=%h, required cT=cB=%h wd=0", cT, cB, word_data, SEED);
        end
        ref_lfsr = SEED;
        @(posedge clk); #1;
        rst_n = 1'b1;
    endtask

    task automatic test_two_words;
        bit ok;
        int hs0;
        hs0 = hs_count;
        flip_reps = 0;
        push_run(2, 0, 1'b0);
        start_run(2);
        wait_done(40000, ok);
        n_checks++;
        if (!ok) begin n_fail++; $display("FAIL two_words_done: got no done, required done pulse"); end
        @(negedge clk);
        n_checks++;
        if (busy !== 1'b0 || done !== 1'b0) begin
            n_fail++;
            $display("FAIL two_words_idle: got busy=%b done=%b, required 0 0", busy, done);
        end
        n_checks++;
        if (hs_count - hs0 != 2 || sb.size() != 0) begin
            n_fail++;
            $display("FAIL two_words_count: got %0d words (%0d left), required 2 (0 left)", hs_count - hs0, sb.size());
        end
    endtask

    task automatic test_majority(input int flips);
        bit ok;
        flip_reps = flips;
        push_run(1, flips, 1'b0);
        start_run(1);
        wait_done(20000, ok);
        n_checks++;
        if (!ok || sb.size() != 0) begin
            n_fail++;
            $display("FAIL majority_%0d: got done=%b left=%0d, required done=1 left=0", flips, ok, sb.size());
        end
        flip_reps = 0;
    endtask

    task automatic test_timeout;
        bit ok;
        int len;
        model_en = 1'b0;
        push_run(1, 0, 1'b1);
        start_run(1);
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if (tigSignal) break;
        end
        len = 0;
        for (int i = 0; i < 200; i++) begin
            if (!tigSignal) break;
            len++;
            @(negedge clk);
        end
        n_checks++;
        if (len != TRIG_W + TO) begin
            n_fail++;
            $display("FAIL timeout_len: got %0d trigger cycles, required %0d", len, TRIG_W + TO);
        end
        wait_done(20000, ok);
        n_checks++;
        if (!ok || timeout_err !== 1'b1 || sb.size() != 0) begin
            n_fail++;
            $display("FAIL timeout_run: got done=%b err=%b left=%0d, required 1 1 0", ok, timeout_err, sb.size());
        end
        model_en = 1'b1;
    endtask

    task automatic test_stall;
        bit ok;
        bit stable;
        logic [31:0] held;
        logic [63:0] cth;
        word_ready = 1'b0;
        push_run(1, 0, 1'b0);
        start_run(1);
        @(negedge clk);
        n_checks++;
        if (timeout_err !== 1'b0) begin
            n_fail++;
            $display("FAIL err_clear: got %b, required 0", timeout_err);
        end
        for (int i = 0; i < 20000; i++) begin
            if (word_valid) break;
            @(negedge clk);
        end
        held = word_data;
        cth = cT;
        stable = word_valid;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (!word_valid || word_data !== held || cT !== cth || tigSignal) stable = 1'b0;
        end
        n_checks++;
        if (!stable) begin
            n_fail++;
            $display("FAIL stall_stable: got valid=%b wd=%h cT=%h tig=%b, required 1 %h %h 0",
                     word_valid, word_data, cT, tigSignal, held, cth);
        end
        @(posedge clk); #1;
        word_ready = 1'b1;
        wait_done(100, ok);
        n_checks++;
        if (!ok || sb.size() != 0) begin
            n_fail++;
            $display("FAIL stall_release: got done=%b left=%0d, required 1 0", ok, sb.size());
        end
    endtask

    task automatic test_seed_start;
        bit ok;
        int hs0;
        @(posedge clk); #1;
        seed = 64'h0123_4567_89AB_CDEF; seed_load = 1'b1;
        @(posedge clk); #1;
        seed_load = 1'b0;
        @(negedge clk);
        n_checks++;
        if (cT !== 64'h0123_4567_89AB_CDEF) begin
            n_fail++;
            $display("FAIL seed_user: got %h, required 0123456789abcdef", cT);
        end
        @(posedge clk); #1;
        seed = 64'd0; seed_load = 1'b1;
        @(posedge clk); #1;
        seed_load = 1'b0;
        @(negedge clk);
        n_checks++;
        if (cT !== SEED) begin
            n_fail++;
            $display("FAIL seed_zero: got %h, required %h", cT, SEED);
        end
        ref_lfsr = SEED;
        hs0 = hs_count;
        push_run(1, 0, 1'b0);
        start_run(1);
        repeat (50) @(negedge clk);
        @(posedge clk); #1;
        start = 1'b1; num_words = 16'd3; seed_load = 1'b1; seed = 64'h5555_AAAA_5555_AAAA;
        @(posedge clk); #1;
        start = 1'b0; seed_load = 1'b0;
        @(negedge clk);
        n_checks++;
        if (cT !== SEED || busy !== 1'b1) begin
            n_fail++;
            $display("FAIL start_ignored: got cT=%h busy=%b, required %h 1", cT, busy, SEED);
        end
        wait_done(20000, ok);
        n_checks++;
        if (!ok || hs_count - hs0 != 1 || sb.size() != 0) begin
            n_fail++;
            $display("FAIL midrun_words: got done=%b words=%0d, required 1 1", ok, hs_count - hs0);
        end
    endtask

    task automatic test_zero_words;
        @(posedge clk); #1;
        num_words = 16'd0; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        @(negedge clk);
        n_checks++;
        if (done !== 1'b1 || busy !== 1'b0) begin
            n_fail++;
            $display("FAIL zero_done: got done=%b busy=%b, required 1 0", done, busy);
        end
        @(negedge clk);
        n_checks++;
        if (done !== 1'b0 || busy !== 1'b0) begin
            n_fail++;
            $display("FAIL zero_after: got done=%b busy=%b, required 0 0", done, busy);
        end
    endtask

    task automatic test_reset_mid;
        bit ok;
        bit saw_done;
        push_run(1, 0, 1'b0);
        start_run(1);
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if (tigSignal) break;
        end
        repeat (6) @(negedge clk);
        rst_n = 1'b0;
        #1;
        n_checks++;
        if (tigSignal !== 1'b0 || word_valid !== 1'b0 || cT !== SEED || busy !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_mid: got tig=%b valid=%b cT=%h busy=%b, required 0 0 %h 0",
                     tigSignal, word_valid, cT, busy, SEED);
        end
        sb.delete();
        ref_lfsr = SEED;
        @(posedge clk); #1;
        rst_n = 1'b1;
        saw_done = 1'b0;
        repeat (30) begin
            @(negedge clk);
            if (done || busy) saw_done = 1'b1;
        end
        n_checks++;
        if (saw_done) begin n_fail++; $display("FAIL reset_no_done: got done/busy activity, required none"); end
        push_run(1, 0, 1'b0);
        start_run(1);
        wait_done(20000, ok);
        n_checks++;
        if (!ok || sb.size() != 0) begin
            n_fail++;
            $display("FAIL restart_run: got done=%b left=%0d, required 1 0", ok, sb.size());
        end
    endtask

    initial begin
        test_reset();
        test_two_words();
        test_majority(3);
        test_majority(4);
        test_timeout();
        test_stall();
        test_seed_start();
        test_zero_words();
        test_reset_mid();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #3_000_000;
        $display("FAIL watchdog: got no completion, required finish within time limit");
        $fatal(1, "watchdog");
    end

endmodule
